tx_sched: RTL and testbench
===========================

TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 156250000, giving clock cycles per statistics window (1 s).
REQ-002 The block SHALL have parameter MIN_LEN, default 64, giving the minimum frame length in bytes; MAX_LEN, default 1518, giving the maximum.
REQ-003 The block SHALL have clk  in  1  clock; all logic on its rising edge.
REQ-004 The block SHALL have rst_n  in  1  reset, synchronous, active-low.
REQ-005 The block SHALL have enable  in  1  level; frame generation allowed.
REQ-006 The block SHALL have req_arp  in  1  one-cycle pulse; request one ARP frame.
REQ-007 The block SHALL have frame_len  in  16  requested frame length in bytes.
REQ-008 The block SHALL have ifg  in  32  inter-frame gap in clk cycles.
REQ-009 The block SHALL have tx_req  out  1  frame request, held until acknowledged.
REQ-010 The block SHALL have tx_arp  out  1  current request is an ARP frame; valid while tx_req.
REQ-011 The block SHALL have tx_len  out  16  current frame length; valid while tx_req.
REQ-012 The block SHALL have tx_ack  in  1  one-cycle pulse; generator accepted the request.
REQ-013 The block SHALL have tx_done  in  1  one-cycle pulse; generator finished the frame.
REQ-014 The block SHALL have busy  out  1  high in any state other than IDLE.
REQ-015 The block SHALL have pps  out  32  frames completed in the last full window.
REQ-016 The block SHALL have throughput  out  32  bytes completed in the last full window.
REQ-017 The block SHALL have wd_err  out  1  sticky watchdog error flag.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT_DONE and GAP.
REQ-019 IDLE SHALL go to REQ when arp_pend=1, or else when enable=1; arp_pend has priority and is served regardless of enable.
REQ-020 On IDLE->REQ, tx_len and tx_arp SHALL be latched: ARP gives tx_arp=1, tx_len=MIN_LEN; a normal frame gives tx_arp=0, tx_len=frame_len clamped to [MIN_LEN, MAX_LEN].
REQ-021 arp_pend SHALL clear on IDLE->REQ for an ARP frame; a req_arp pulse while arp_pend=1 SHALL merge; a req_arp arriving in the same cycle as the clear SHALL set arp_pend again.
REQ-022 In REQ, tx_req=1; on tx_ack the FSM SHALL go to WAIT_DONE with tx_req=0 in the next cycle; a tx_ack outside REQ SHALL be ignored.
REQ-023 WAIT_DONE SHALL go to GAP on tx_done; GAP SHALL load a counter with ifg, decrement each cycle, and return to IDLE when the count is 0 (ifg=0: GAP lasts exactly 1 cycle).
REQ-024 Deasserting enable mid-frame SHALL NOT abort the frame; the frame completes and GAP still applies.
REQ-025 A free-running window counter SHALL wrap at CLK_HZ-1; at the wrap cycle, pps and throughput SHALL load the running counts (including any tx_done in that cycle), and the running counts SHALL restart from 0.
REQ-026 Running counts SHALL saturate at 32'hFFFFFFFF; the byte count SHALL add tx_len on each tx_done, with ARP frames counted as well.

Reset
REQ-027 On reset: state=IDLE, tx_req=0, tx_arp=0, tx_len=0, busy=0, arp_pend=0, pps=0, throughput=0, window and running counters=0, wd_err=0.
REQ-028 Reset mid-frame SHALL abandon the frame immediately, with no tx_req in the cycle following release.

Configuration
REQ-029 With TX_SCHED_WATCHDOG_EN defined, WAIT_DONE SHALL count cycles; if no tx_done arrives within 65535 cycles, wd_err SHALL be set and the FSM SHALL go to GAP, with no frame counted.
REQ-030 Without TX_SCHED_WATCHDOG_EN, no watchdog logic SHALL exist, wd_err SHALL be tied to 0, and WAIT_DONE SHALL wait indefinitely.

Verification
REQ-031 enable=1, frame_len=100, ifg=10, ack 2 cycles after req, done 20 cycles after ack -> tx_len=100, tx_arp=0, and the next tx_req rises 12 cycles after done (1 to enter GAP, 10 counting, 1 in IDLE).
REQ-032 frame_len=20, then 9000 -> tx_len=64, then 1518.
REQ-033 enable=0, single req_arp pulse -> exactly one request with tx_arp=1, tx_len=64; then idle. Two req_arp pulses while a frame is in WAIT_DONE -> exactly one ARP frame, issued before the next normal frame.
REQ-034 CLK_HZ=1000, ifg=0, done 5 cycles after ack, frame_len=64 -> pps and throughput update only at the window wrap, with throughput = 64*pps.
REQ-035 With TX_SCHED_WATCHDOG_EN, tx_done is never driven -> wd_err=1 at 65535 cycles after ack, then GAP, then IDLE. Without the macro -> busy stays 1 and wd_err=0.
REQ-036 Assert rst_n=0 during WAIT_DONE -> all outputs match REQ-027 after one clock.

Source files
------------

// File: rtl/tx_sched_if.sv
// tx_sched_if -- request/acknowledge handshake between the frame scheduler
// and the frame generator. The scheduler is the master: it offers a frame
// (tx_req, tx_arp, tx_len) and the generator answers with tx_ack and tx_done.
`timescale 1ns/1ps

interface tx_sched_if;
   logic        tx_req;
   logic        tx_arp;
   logic [15:0] tx_len;
   logic        tx_ack;
   logic        tx_done;

   modport master (
      output tx_req,
      output tx_arp,
      output tx_len,
      input  tx_ack,
      input  tx_done
   );

   modport slave (
      input  tx_req,
      input  tx_arp,
      input  tx_len,
      output tx_ack,
      output tx_done
   );
endinterface

// File: rtl/tx_sched.sv
// tx_sched -- frame request scheduler with ARP injection, inter-frame gap
// and per-window frame/byte statistics.
// Optional feature: define TX_SCHED_WATCHDOG_EN to add a WAIT_DONE watchdog
// that raises the sticky wd_err flag when the generator never reports
// completion; without it wd_err is constant 0 and WAIT_DONE waits forever.
`timescale 1ns/1ps

module tx_sched #(
   parameter int unsigned CLK_HZ  = 156250000,
   parameter int unsigned MIN_LEN = 64,
   parameter int unsigned MAX_LEN = 1518
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        req_arp,
   input  logic [15:0] frame_len,
   input  logic [31:0] ifg,
   tx_sched_if.master  tx,
   output logic        busy,
   output logic [31:0] pps,
   output logic [31:0] throughput,
   output logic        wd_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, GAP} state_t;

   localparam logic [15:0] MIN_LEN16 = 16'(MIN_LEN);
   localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);
   localparam logic [31:0] WIN_LAST  = 32'(CLK_HZ - 1);

   state_t      state;
   logic        arp_pend;
   logic        serve_arp;
   logic        frame_done;
   logic [31:0] gap_cnt;
   logic [15:0] len_clamped;
   logic [31:0] win_cnt;
   logic [31:0] run_frames;
   logic [31:0] run_bytes;
   logic [31:0] frames_next;
   logic [31:0] bytes_next;
   logic [32:0] bytes_sum;

`ifdef TX_SCHED_WATCHDOG_EN
   logic [15:0] wd_cnt;
   logic        wd_err_q;
   assign wd_err = wd_err_q;
`else
   assign wd_err = 1'b0;
`endif

   // A pending ARP is consumed on the cycle IDLE hands it to REQ.
   assign serve_arp  = (state == IDLE) && arp_pend;
   assign frame_done = (state == WAIT_DONE) && tx.tx_done;

   // Clamp the requested length into the legal frame size range.
   always_comb begin
      len_clamped = frame_len;
      if (frame_len < MIN_LEN16) begin
         len_clamped = MIN_LEN16;
      end else if (frame_len > MAX_LEN16) begin
         len_clamped = MAX_LEN16;
      end
   end

   // Next running counts, saturating so a long window never wraps to a small value.
   always_comb begin
      frames_next = run_frames;
      bytes_next  = run_bytes;
      bytes_sum   = {1'b0, run_bytes} + 33'(tx.tx_len);
      if (frame_done) begin
         if (run_frames != 32'hFFFF_FFFF) begin
            frames_next = run_frames + 32'd1;
         end
         bytes_next = bytes_sum[32] ? 32'hFFFF_FFFF : bytes_sum[31:0];
      end
   end

   // Statistics window: publish the running counts on the wrap cycle and restart them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_cnt    <= '0;
         run_frames <= '0;
         run_bytes  <= '0;
         pps        <= '0;
         throughput <= '0;
      end else if (win_cnt == WIN_LAST) begin
         win_cnt    <= '0;
         run_frames <= '0;
         run_bytes  <= '0;
         pps        <= frames_next;
         throughput <= bytes_next;
      end else begin
         win_cnt    <= win_cnt + 32'd1;
         run_frames <= frames_next;
         run_bytes  <= bytes_next;
      end
   end

   // Scheduler FSM with registered handshake outputs and ARP pending flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         tx.tx_req <= 1'b0;
         tx.tx_arp <= 1'b0;
         tx.tx_len <= '0;
         busy      <= 1'b0;
         arp_pend  <= 1'b0;
         gap_cnt   <= '0;
`ifdef TX_SCHED_WATCHDOG_EN
         wd_cnt    <= '0;
         wd_err_q  <= 1'b0;
`endif
      end else begin
         arp_pend <= (arp_pend && !serve_arp) || req_arp;
         case (state)
            IDLE: begin
               if (arp_pend) begin
                  state     <= REQ;
                  tx.tx_req <= 1'b1;
                  tx.tx_arp <= 1'b1;
                  tx.tx_len <= MIN_LEN16;
                  busy      <= 1'b1;
               end else if (enable) begin
                  state     <= REQ;
                  tx.tx_req <= 1'b1;
                  tx.tx_arp <= 1'b0;
                  tx.tx_len <= len_clamped;
                  busy      <= 1'b1;
               end
            end
            REQ: begin
               if (tx.tx_ack) begin
                  state     <= WAIT_DONE;
                  tx.tx_req <= 1'b0;
`ifdef TX_SCHED_WATCHDOG_EN
                  wd_cnt    <= '0;
`endif
               end
            end
            WAIT_DONE: begin
               if (tx.tx_done) begin
                  state   <= GAP;
                  gap_cnt <= ifg;
`ifdef TX_SCHED_WATCHDOG_EN
               end else if (wd_cnt == 16'hFFFE) begin
                  state    <= GAP;
                  gap_cnt  <= ifg;
                  wd_err_q <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 16'd1;
`endif
               end
            end
            GAP: begin
               if (gap_cnt == 32'd0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - 32'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched -- directed self-checking bench for tx_sched. A transaction
// level model (phases plus absolute cycle stamps) predicts every output each
// cycle; directed sequences add hand-computed literal expectations.
`timescale 1ns/1ps

module tb_tx_sched;
   localparam int unsigned CLK_HZ  = 1000;
   localparam int unsigned MIN_LEN = 64;
   localparam int unsigned MAX_LEN = 1518;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        enable    = 1'b0;
   logic        req_arp   = 1'b0;
   logic [15:0] frame_len = 16'd0;
   logic [31:0] ifg       = 32'd0;
   logic        busy;
   logic [31:0] pps;
   logic [31:0] throughput;
   logic        wd_err;

   int checks = 0;
   int errors = 0;

   tx_sched_if tx ();

   tx_sched #(
      .CLK_HZ (CLK_HZ),
      .MIN_LEN(MIN_LEN),
      .MAX_LEN(MAX_LEN)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .req_arp   (req_arp),
      .frame_len (frame_len),
      .ifg       (ifg),
      .tx        (tx),
      .busy      (busy),
      .pps       (pps),
      .throughput(throughput),
      .wd_err    (wd_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {PH_FREE, PH_OFFERED, PH_SENDING, PH_COOLDOWN} phase_t;

   phase_t      ph = PH_FREE;
   longint      now = 0;
   longint      ack_at = 0;
   longint      free_at = 0;
   longint      run_f = 0;
   longint      run_b = 0;
   bit          m_pend = 0;
   bit          m_req = 0;
   bit          m_busy = 0;
   bit          m_arp = 0;
   bit          m_wd = 0;
   bit          model_ok = 0;
   logic [31:0] m_len = 0;
   logic [31:0] m_pps = 0;
   logic [31:0] m_thr = 0;

   function automatic logic [31:0] sat32(input longint v);
      if (v > longint'(32'hFFFF_FFFF)) return 32'hFFFF_FFFF;
      return 32'(v);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         ph = PH_FREE; now = 0; m_pend = 0; run_f = 0; run_b = 0;
         m_len = 0; m_arp = 0; m_pps = 0; m_thr = 0; m_wd = 0;
         model_ok = 1;
      end else begin
         bit          done_now;
         bit          serve;
         int unsigned want;
         done_now = (ph == PH_SENDING) && tx.tx_done;
         if (done_now) begin
            run_f = run_f + 1;
            run_b = run_b + longint'(m_len);
         end
         if (now % CLK_HZ == CLK_HZ - 1) begin
            m_pps = sat32(run_f);
            m_thr = sat32(run_b);
            run_f = 0;
            run_b = 0;
         end
         serve = (ph == PH_FREE) && m_pend;
         case (ph)
            PH_FREE: begin
               if (m_pend) begin
                  ph = PH_OFFERED; m_arp = 1; m_len = MIN_LEN;
               end else if (enable) begin
                  ph = PH_OFFERED; m_arp = 0;
                  want = frame_len;
                  m_len = (want < MIN_LEN) ? MIN_LEN : ((want > MAX_LEN) ? MAX_LEN : want);
               end
            end
            PH_OFFERED: if (tx.tx_ack) begin ph = PH_SENDING; ack_at = now; end
            PH_SENDING: begin
               if (done_now) begin
                  ph = PH_COOLDOWN; free_at = now + longint'(ifg) + 1;
`ifdef TX_SCHED_WATCHDOG_EN
               end else if (now - ack_at == 65535) begin
                  ph = PH_COOLDOWN; free_at = now + longint'(ifg) + 1; m_wd = 1;
`endif
               end
            end
            PH_COOLDOWN: if (now == free_at) ph = PH_FREE;
            default: ph = PH_FREE;
         endcase
         m_pend = (m_pend && !serve) || req_arp;
         now = now + 1;
      end
      m_req  = (ph == PH_OFFERED);
      m_busy = (ph != PH_FREE);
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (model_ok) begin
         checkOutput("cyc_tx_req", tx.tx_req, m_req);
         checkOutput("cyc_busy", busy, m_busy);
         if (m_req) begin
            checkOutput("cyc_tx_arp", tx.tx_arp, m_arp);
            checkOutput("cyc_tx_len", tx.tx_len, m_len);
         end
         checkOutput("cyc_pps", pps, m_pps);
         checkOutput("cyc_throughput", throughput, m_thr);
         checkOutput("cyc_wd_err", wd_err, m_wd);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic [15:0] len, input logic [31:0] gap);
      enable    = en;
      frame_len = len;
      ifg       = gap;
   endtask

   task automatic waitReq(input string name);
      int n = 0;
      while (!tx.tx_req && n < 200) begin step(); n++; end
      checkOutput(name, tx.tx_req, 1);
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while (busy && n < 200) begin step(); n++; end
      checkOutput(name, busy, 0);
   endtask

   task automatic ackAfter(input int k);
      repeat (k - 1) step();
      tx.tx_ack = 1'b1;
      step();
      tx.tx_ack = 1'b0;
   endtask

   task automatic doneAfter(input int k);
      repeat (k - 1) step();
      tx.tx_done = 1'b1;
      step();
      tx.tx_done = 1'b0;
   endtask

   task automatic pulseArp();
      req_arp = 1'b1;
      step();
      req_arp = 1'b0;
   endtask

   initial begin
      int n;
      tx.tx_ack  = 1'b0;
      tx.tx_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_tx_req", tx.tx_req, 0);
      checkOutput("rst_tx_arp", tx.tx_arp, 0);
      checkOutput("rst_tx_len", tx.tx_len, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_pps", pps, 0);
      checkOutput("rst_throughput", throughput, 0);
      checkOutput("rst_wd_err", wd_err, 0);
      rst_n = 1'b1;

      // Basic frame with a 10-cycle gap.
      applyStimulus(1'b1, 16'd100, 32'd10);
      waitReq("t1_req");
      checkOutput("t1_len", tx.tx_len, 100);
      checkOutput("t1_arp", tx.tx_arp, 0);
      ackAfter(2);
      doneAfter(20);
      n = 0;
      while (!tx.tx_req && n < 100) begin step(); n++; end
      checkOutput("t1_done_to_req", n, 12);

      // Length clamping at both ends.
      applyStimulus(1'b1, 16'd20, 32'd2);
      ackAfter(1);
      doneAfter(3);
      waitReq("t2_req_short");
      checkOutput("t2_len_min", tx.tx_len, 64);
      applyStimulus(1'b1, 16'd9000, 32'd2);
      ackAfter(1);
      doneAfter(3);
      waitReq("t2_req_long");
      checkOutput("t2_len_max", tx.tx_len, 1518);

      // ARP served with enable low, exactly once.
      applyStimulus(1'b0, 16'd200, 32'd2);
      ackAfter(1);
      doneAfter(3);
      waitIdle("t3_idle_a");
      pulseArp();
      waitReq("t3_arp_req");
      checkOutput("t3_arp_flag", tx.tx_arp, 1);
      checkOutput("t3_arp_len", tx.tx_len, 64);
      ackAfter(1);
      doneAfter(2);
      waitIdle("t3_idle_b");
      n = 0;
      repeat (20) begin step(); if (tx.tx_req) n++; end
      checkOutput("t3_no_extra_req", n, 0);

      // Two merged ARP pulses during WAIT_DONE give one ARP ahead of the next normal frame.
      applyStimulus(1'b1, 16'd200, 32'd2);
      waitReq("t3_norm_req");
      checkOutput("t3_norm_arp", tx.tx_arp, 0);
      checkOutput("t3_norm_len", tx.tx_len, 200);
      ackAfter(1);
      pulseArp();
      step();
      pulseArp();
      doneAfter(3);
      waitReq("t3_merged_req");
      checkOutput("t3_merged_is_arp", tx.tx_arp, 1);
      ackAfter(1);
      doneAfter(2);
      waitReq("t3_after_arp_req");
      checkOutput("t3_after_arp_normal", tx.tx_arp, 0);
      checkOutput("t3_after_arp_len", tx.tx_len, 200);
      ackAfter(1);
      doneAfter(2);

      // Statistics: 8-cycle frame period gives 125 frames and 8000 bytes per 1000-cycle window.
      applyStimulus(1'b1, 16'd64, 32'd0);
      repeat (400) begin
         waitReq("t4_req");
         ackAfter(1);
         doneAfter(5);
      end
      checkOutput("t4_pps", pps, 125);
      checkOutput("t4_throughput", throughput, 8000);
      checkOutput("t4_thr_is_64_pps", throughput, 64 * pps);

      // Reset during WAIT_DONE.
      applyStimulus(1'b1, 16'd100, 32'd3);
      waitReq("t5_req");
      ackAfter(1);
      rst_n = 1'b0;
      step();
      checkOutput("t5_tx_req", tx.tx_req, 0);
      checkOutput("t5_tx_arp", tx.tx_arp, 0);
      checkOutput("t5_tx_len", tx.tx_len, 0);
      checkOutput("t5_busy", busy, 0);
      checkOutput("t5_pps", pps, 0);
      checkOutput("t5_throughput", throughput, 0);
      checkOutput("t5_wd_err", wd_err, 0);
      rst_n = 1'b1;
      checkOutput("t5_release_no_req", tx.tx_req, 0);

      // Generator never finishes the frame.
      waitReq("t6_req");
      ackAfter(1);
      applyStimulus(1'b0, 16'd100, 32'd3);
`ifdef TX_SCHED_WATCHDOG_EN
      n = 0;
      while (!wd_err && n < 70000) begin step(); n++; end
      checkOutput("t6_wd_time", n, 65535);
      checkOutput("t6_wd_in_gap", busy, 1);
      waitIdle("t6_back_idle");
      checkOutput("t6_wd_sticky", wd_err, 1);
`else
      repeat (300) step();
      checkOutput("t6_busy_hold", busy, 1);
      checkOutput("t6_no_wd", wd_err, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #1500000;
      errors++;
      $display("[TB] FAIL global_timeout: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
